// File: rtl/regfile_sb_if.sv
// Register-file bus: two read ports, the write-back port, the issue port and the debug read port.
// The master side is decode/write-back (or a bench); the slave side is the register file.
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              busy1;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;
    logic              busy2;
    logic              wen;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              issue_en;
    logic [ADDR_W-1:0] issue_addr;
    logic [DEPTH-1:0]  busy_vec;
    logic              sb_err;
    logic [ADDR_W-1:0] test_addr;
    logic [DATA_W-1:0] test_data;

    modport master (
        output raddr1, raddr2, wen, waddr, wdata, issue_en, issue_addr, test_addr,
        input  rdata1, busy1, rdata2, busy2, busy_vec, sb_err, test_data
    );

    modport slave (
        input  raddr1, raddr2, wen, waddr, wdata, issue_en, issue_addr, test_addr,
        output rdata1, busy1, rdata2, busy2, busy_vec, sb_err, test_data
    );
endinterface

// File: rtl/regfile_sb.sv
// General-purpose register file with optional write-to-read bypass and a per-register
// busy scoreboard that decode uses to stall on pending write-backs.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic         clk,
    input logic         resetn,
    regfile_sb_if.slave bus
);
    localparam int DEPTH   = 2 ** ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 0);
    localparam bit BYP_EN  = (BYPASS != 0);

    logic [DATA_W-1:0] rf [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic              sb_err_q, sb_err_d;

    logic wr_ok, issue_ok, issue_retired;
    logic zero1, zero2, zero_t;
    logic hit1, hit2;

    assign wr_ok         = bus.wen && !(ZERO_EN && bus.waddr == '0);
    assign issue_ok      = bus.issue_en && !(ZERO_EN && bus.issue_addr == '0);
    assign issue_retired = bus.wen && (bus.waddr == bus.issue_addr);

    assign zero1  = ZERO_EN && (bus.raddr1 == '0);
    assign zero2  = ZERO_EN && (bus.raddr2 == '0);
    assign zero_t = ZERO_EN && (bus.test_addr == '0);
    assign hit1   = BYP_EN && bus.wen && (bus.waddr == bus.raddr1);
    assign hit2   = BYP_EN && bus.wen && (bus.waddr == bus.raddr2);

    // NOTE: the whole array is cleared asynchronously on reset, so it maps to flops, not RAM;
    // decode relies on every register reading 0 the moment reset is applied.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
        end else if (wr_ok) begin
            // NOTE: sequential state is always updated with <= so every flop samples pre-edge values.
            rf[bus.waddr] <= bus.wdata;
        end
    end

    // Retire clears first, issue sets after, so a same-edge issue to the retiring register wins.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        busy_d   = busy_q;
        sb_err_d = sb_err_q;
        if (bus.wen)  busy_d[bus.waddr]      = 1'b0;
        if (issue_ok) busy_d[bus.issue_addr] = 1'b1;
        if (bus.issue_en && busy_q[bus.issue_addr] && !issue_retired) sb_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q   <= '0;
            sb_err_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            sb_err_q <= sb_err_d;
        end
    end

    // Reads are gated by resetn so a bypass hit cannot leak wdata while reset is held.
    always_comb begin
        bus.rdata1 = '0;
        bus.rdata2 = '0;
        if (resetn && !zero1) bus.rdata1 = hit1 ? bus.wdata : rf[bus.raddr1];
        if (resetn && !zero2) bus.rdata2 = hit2 ? bus.wdata : rf[bus.raddr2];
    end

    assign bus.busy1     = busy_q[bus.raddr1] && !hit1;
    assign bus.busy2     = busy_q[bus.raddr2] && !hit2;
    assign bus.test_data = zero_t ? '0 : rf[bus.test_addr];
    assign bus.busy_vec  = busy_q;
    assign bus.sb_err    = sb_err_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: stimulus pushes expected values into a queue and a
// monitor process compares them against the DUT at each sample point.
module tb_regfile_sb;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #10 clk = ~clk;

    regfile_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) rf_if ();
    regfile_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) nb_if ();

    regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .resetn(resetn), .bus(rf_if)
    );
    regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .resetn(resetn), .bus(nb_if)
    );

    // The no-bypass instance mirrors every input of the main one.
    assign nb_if.raddr1     = rf_if.raddr1;
    assign nb_if.raddr2     = rf_if.raddr2;
    assign nb_if.wen        = rf_if.wen;
    assign nb_if.waddr      = rf_if.waddr;
    assign nb_if.wdata      = rf_if.wdata;
    assign nb_if.issue_en   = rf_if.issue_en;
    assign nb_if.issue_addr = rf_if.issue_addr;
    assign nb_if.test_addr  = rf_if.test_addr;

    typedef enum {S_RDATA1, S_RDATA2, S_BUSY1, S_BUSY2, S_BUSY_VEC, S_SB_ERR, S_TEST_DATA,
                  S_RDATA1_NB} sel_e;
    typedef struct {
        string       name;
        sel_e        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    event sample_ev;

    function automatic logic [31:0] probe(input sel_e s);
        case (s)
            S_RDATA1:    return rf_if.rdata1;
            S_RDATA2:    return rf_if.rdata2;
            S_BUSY1:     return {31'b0, rf_if.busy1};
            S_BUSY2:     return {31'b0, rf_if.busy2};
            S_BUSY_VEC:  return 32'(rf_if.busy_vec);
            S_SB_ERR:    return {31'b0, rf_if.sb_err};
            S_TEST_DATA: return rf_if.test_data;
            default:     return nb_if.rdata1;
        endcase
    endfunction

    // Monitor: drains the expectation queue each time the stimulus presents a sample point.
    initial begin
        forever begin
            @(sample_ev);
            while (exp_q.size() > 0) begin
                exp_t        e;
                logic [31:0] act;
                e   = exp_q.pop_front();
                act = probe(e.sel);
                vectors++;
                if (act !== e.exp) begin
                    miscompares++;
                    $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic push_exp(input string name, input sel_e sel, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        exp_q.push_back(e);
    endtask

    task automatic sample();
        #1;
        ->sample_ev;
        #1;
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL monitor_timeout: %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rf_if.raddr1 = '0; rf_if.raddr2 = '0; rf_if.wen = 1'b0; rf_if.waddr = '0;
        rf_if.wdata = '0; rf_if.issue_en = 1'b0; rf_if.issue_addr = '0; rf_if.test_addr = '0;

        // Reset held: a bypass-eligible write must not show through.
        #3;
        rf_if.wen = 1'b1; rf_if.waddr = 5'd5; rf_if.wdata = 32'hCAFE_F00D; rf_if.raddr1 = 5'd5;
        push_exp("reset_rdata1_gated", S_RDATA1, 32'h0);
        push_exp("reset_busy_vec", S_BUSY_VEC, 32'h0);
        push_exp("reset_sb_err", S_SB_ERR, 32'h0);
        push_exp("reset_busy1", S_BUSY1, 32'h0);
        sample();
        rf_if.wen = 1'b0;
        #7 resetn = 1'b1;

        // Write r5 and issue r6, then clear both with a mid-cycle reset pulse.
        tick();
        rf_if.wen = 1'b1; rf_if.waddr = 5'd5; rf_if.wdata = 32'hDEAD_BEEF;
        rf_if.issue_en = 1'b1; rf_if.issue_addr = 5'd6;
        tick();
        rf_if.wen = 1'b0; rf_if.issue_en = 1'b0; rf_if.test_addr = 5'd5;
        push_exp("r5_written", S_RDATA1, 32'hDEAD_BEEF);
        push_exp("r5_test_data", S_TEST_DATA, 32'hDEAD_BEEF);
        push_exp("r6_busy", S_BUSY_VEC, 32'h0000_0040);
        sample();
        resetn = 1'b0;
        push_exp("pulse_rdata1_r5", S_RDATA1, 32'h0);
        push_exp("pulse_test_r5", S_TEST_DATA, 32'h0);
        push_exp("pulse_busy_vec", S_BUSY_VEC, 32'h0);
        push_exp("pulse_sb_err", S_SB_ERR, 32'h0);
        sample();
        resetn = 1'b1;

        // Write r7; then a write to r0 is dropped and never forwarded.
        tick();
        rf_if.wen = 1'b1; rf_if.waddr = 5'd7; rf_if.wdata = 32'h1234_5678;
        tick();
        rf_if.waddr = 5'd0; rf_if.wdata = 32'hFFFF_FFFF; rf_if.raddr2 = 5'd7; rf_if.raddr1 = 5'd0;
        push_exp("r7_read", S_RDATA2, 32'h1234_5678);
        push_exp("r0_no_bypass", S_RDATA1, 32'h0);
        sample();
        tick();
        rf_if.wen = 1'b0; rf_if.test_addr = 5'd0;
        push_exp("r0_after_write", S_RDATA1, 32'h0);
        push_exp("r0_test_data", S_TEST_DATA, 32'h0);
        sample();

        // Bypass: r3=0x11 stored, same-cycle write of 0x22.
        rf_if.wen = 1'b1; rf_if.waddr = 5'd3; rf_if.wdata = 32'h11;
        tick();
        rf_if.wdata = 32'h22; rf_if.raddr1 = 5'd3; rf_if.test_addr = 5'd3;
        push_exp("bypass_rdata1", S_RDATA1, 32'h22);
        push_exp("bypass_test_data", S_TEST_DATA, 32'h11);
        push_exp("nobypass_rdata1", S_RDATA1_NB, 32'h11);
        sample();
        tick();
        rf_if.wen = 1'b0;
        push_exp("r3_after_edge", S_RDATA1, 32'h22);
        push_exp("r3_after_edge_nb", S_RDATA1_NB, 32'h22);
        push_exp("r3_test_after_edge", S_TEST_DATA, 32'h22);
        sample();

        // Scoreboard set by issue, cleared by retire (busy masked in the retiring cycle).
        rf_if.issue_en = 1'b1; rf_if.issue_addr = 5'd9;
        tick();
        rf_if.issue_en = 1'b0; rf_if.raddr1 = 5'd9; rf_if.raddr2 = 5'd9;
        push_exp("r9_busy_vec", S_BUSY_VEC, 32'h0000_0200);
        push_exp("r9_busy1", S_BUSY1, 32'h1);
        push_exp("r9_busy2", S_BUSY2, 32'h1);
        sample();
        rf_if.wen = 1'b1; rf_if.waddr = 5'd9; rf_if.wdata = 32'h99;
        push_exp("r9_retire_busy1", S_BUSY1, 32'h0);
        push_exp("r9_retire_busy2", S_BUSY2, 32'h0);
        push_exp("r9_retire_busy_vec", S_BUSY_VEC, 32'h0000_0200);
        sample();
        tick();
        rf_if.wen = 1'b0;
        push_exp("r9_cleared_vec", S_BUSY_VEC, 32'h0);
        push_exp("r9_cleared_busy1", S_BUSY1, 32'h0);
        sample();

        // Simultaneous issue and retire of r4: set wins, no error; a lone re-issue errors.
        rf_if.issue_en = 1'b1; rf_if.issue_addr = 5'd4;
        tick();
        rf_if.issue_en = 1'b0;
        push_exp("r4_busy", S_BUSY_VEC, 32'h0000_0010);
        sample();
        rf_if.issue_en = 1'b1; rf_if.wen = 1'b1; rf_if.waddr = 5'd4; rf_if.wdata = 32'h44;
        tick();
        rf_if.issue_en = 1'b0; rf_if.wen = 1'b0;
        push_exp("r4_same_edge_vec", S_BUSY_VEC, 32'h0000_0010);
        push_exp("r4_same_edge_err", S_SB_ERR, 32'h0);
        sample();
        rf_if.issue_en = 1'b1;
        tick();
        rf_if.issue_en = 1'b0;
        push_exp("r4_reissue_err", S_SB_ERR, 32'h1);
        push_exp("r4_reissue_vec", S_BUSY_VEC, 32'h0000_0010);
        sample();
        rf_if.wen = 1'b1; rf_if.waddr = 5'd4; rf_if.issue_en = 1'b1; rf_if.issue_addr = 5'd12;
        tick();
        rf_if.issue_en = 1'b0; rf_if.waddr = 5'd12;
        push_exp("diff_addr_vec", S_BUSY_VEC, 32'h0000_1000);
        push_exp("err_sticky_1", S_SB_ERR, 32'h1);
        sample();
        tick();
        rf_if.wen = 1'b0;
        push_exp("r12_cleared_vec", S_BUSY_VEC, 32'h0);
        push_exp("err_sticky_2", S_SB_ERR, 32'h1);
        sample();
        resetn = 1'b0;
        push_exp("err_reset", S_SB_ERR, 32'h0);
        sample();
        resetn = 1'b1;

        // r0 is never busy and repeated issues to it never error; retiring a non-busy reg is legal.
        tick();
        rf_if.issue_en = 1'b1; rf_if.issue_addr = 5'd0;
        tick();
        tick();
        rf_if.issue_en = 1'b0; rf_if.raddr1 = 5'd0;
        push_exp("r0_busy_vec", S_BUSY_VEC, 32'h0);
        push_exp("r0_sb_err", S_SB_ERR, 32'h0);
        push_exp("r0_busy1", S_BUSY1, 32'h0);
        sample();
        rf_if.wen = 1'b1; rf_if.waddr = 5'd13; rf_if.wdata = 32'h1313;
        tick();
        rf_if.wen = 1'b0;
        push_exp("idle_retire_err", S_SB_ERR, 32'h0);
        push_exp("idle_retire_vec", S_BUSY_VEC, 32'h0);
        sample();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file for the pipelined CPU. It has two combinational read ports, one synchronous write port, and a debug/test read port. It adds three things: optional write-to-read bypass, asynchronous clear of all registers on reset, and a per-register busy scoreboard that decode uses to detect pending write-backs. It sits between the decode stage, which reads and issues, and the write-back stage, which writes and retires.

## Interface
Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, is never busy.
- BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- raddr1  in  ADDR_W  read port 1 address.
- rdata1  out  DATA_W  read port 1 data, combinational.
- busy1  out  1  scoreboard busy bit of raddr1, combinational.
- raddr2  in  ADDR_W  read port 2 address.
- rdata2  out  DATA_W  read port 2 data, combinational.
- busy2  out  1  scoreboard busy bit of raddr2, combinational.
- wen  in  1  write enable (write-back/retire).
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- issue_en  in  1  marks issue_addr as having a pending write.
- issue_addr  in  ADDR_W  destination register being issued.
- busy_vec  out  DEPTH  registered busy bits, bit i = register i.
- sb_err  out  1  sticky scoreboard error flag.
- test_addr  in  ADDR_W  debug read address.
- test_data  out  DATA_W  debug read data, combinational, never bypassed.

## Operation
- Reset (resetn=0, asynchronous):
  - every register clears to 0;
  - busy_vec clears to 0;
  - sb_err clears to 0.
  - While reset is held, the read outputs show 0 for any address. busy1 and busy2 are 0.
- Write:
  - At a clk edge with wen=1, rf[waddr] <= wdata.
  - When ZERO_REG=1 and waddr=0, the write is dropped.
- Read (per port, combinational):
  - ZERO_REG=1 and addr=0 → 0.
  - Otherwise, BYPASS=1, wen=1 and waddr=addr → wdata.
  - Otherwise → rf[addr].
- test_data = rf[test_addr]. Register 0 reads 0 when ZERO_REG=1.
- Scoreboard, evaluated at each clk edge:
  - wen=1 clears busy[waddr].
  - issue_en=1 sets busy[issue_addr].
  - Same edge, same address: the set wins, so the new issue stays pending.
  - Different addresses: both take effect.
  - With ZERO_REG=1, address 0 is never set.
- busy1/busy2:
  - Normally busy_vec[raddr].
  - When BYPASS=1, and wen=1 with waddr=raddr this cycle, the output is 0. The data is already forwarded.
- sb_err:
  - Set at the edge where issue_en=1 targets a register that is already busy, unless the same edge also retires it (wen=1, waddr=issue_addr).
  - Retiring a non-busy register is legal: a plain write with no error.
  - Once set, sb_err holds until reset.
- No internal FSM beyond the scoreboard bits. There is no handshake: the caller must stall on busy1/busy2.

## Timing
- Read latency 0 cycles (combinational).
- Write visible through rf and test_data 1 cycle after the edge. It is visible on the same cycle through the read ports when BYPASS=1.
- busy_vec updates 1 edge after issue_en or wen.
- Deasserting reset between edges takes effect at the next rising edge. A reset pulse mid-operation discards all pending writes and busy state immediately.
- All outputs are defined at every cycle. There are no X values after reset.

## Test plan
- Reset clear: write 0xDEADBEEF to r5, pulse resetn low mid-cycle → rdata1(r5)=0, busy_vec=0, sb_err=0 with no clock edge.
- Write/read and r0:
  - wen, waddr=7, wdata=0x12345678 → rdata2(r7)=0x12345678 after the edge.
  - A write of 0xFFFFFFFF to r0 → rdata1(r0)=0.
- Bypass, BYPASS=1:
  - r3=0x11 stored; same cycle wen, waddr=3, wdata=0x22 → rdata1(r3)=0x22 and test_data(r3)=0x11 before the edge.
  - With BYPASS=0, rdata1(r3)=0x11 before the edge.
- Scoreboard set/clear:
  - issue r9 → busy_vec[9]=1 next cycle and busy1(r9)=1.
  - wen r9 → busy1(r9)=0 in that cycle (BYPASS=1), busy_vec[9]=0 after the edge.
- Simultaneous events:
  - r4 busy; issue r4 and wen r4 at the same edge → busy_vec[4]=1, sb_err=0.
  - Then issue r4 alone → sb_err=1, and it stays 1 through further writes until reset.
- r0 scoreboard: issue_addr=0 → busy_vec[0]=0 and sb_err stays 0 on repeat issues (ZERO_REG=1).
